mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 144 ++++++++++++++
 tb/tb_mem_access_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory access unit: store buffer with youngest-match load forwarding, plus a
// single-outstanding memory port FSM that drains stores and services load misses.
module mem_access_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic                    req_write,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  output logic                    req_ready,
  output logic                    resp_valid,
  output logic [DATA_W-1:0]       resp_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic                    mem_ack,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic                    stall,
  output logic [$clog2(DEPTH):0]  sb_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {M_IDLE, M_STORE, M_LOAD} mstate_t;

  mstate_t             state;
  logic [PTR_W-1:0]    head, tail, idx;
  logic                miss_busy, miss_issue;
  logic [ADDR_W-1:0]   miss_addr;
  logic [ADDR_W-1:0]   sb_addr [DEPTH];
  logic [DATA_W-1:0]   sb_data [DEPTH];
  logic                hit;
  logic [DATA_W-1:0]   hit_data;
  logic                accept, enq, deq, ld_acc;

  // A full buffer refuses stores even when the head drains this same cycle.
  assign req_ready = ~miss_busy & ~(req_write & (sb_count == CNT_W'(DEPTH)));
  assign stall     = req_valid & ~req_ready;
  assign accept    = req_valid & req_ready;
  assign enq       = accept & req_write;
  assign ld_acc    = accept & ~req_write;
  assign deq       = (state == M_STORE) & mem_ack;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    // NOTE: every variable gets a default first so no latch is inferred.
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if ((CNT_W'(k) < sb_count) && (sb_addr[idx] == req_addr)) begin
        hit      = 1'b1;
        hit_data = sb_data[idx];
      end
    end
  end

  // NOTE: the buffer storage carries no reset; occupancy is tracked by sb_count.
  always_ff @(posedge clock) begin
    if (enq) begin
      sb_addr[tail] <= req_addr;
      sb_data[tail] <= req_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state      <= M_IDLE;
      head       <= '0;
      tail       <= '0;
      sb_count   <= '0;
      miss_busy  <= 1'b0;
      miss_issue <= 1'b0;
      miss_addr  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      sb_count <= sb_count + CNT_W'(enq) - CNT_W'(deq);

      if (ld_acc) begin
        if (hit) begin
          resp_valid <= 1'b1;
          resp_rdata <= hit_data;
        end else begin
          miss_busy  <= 1'b1;
          miss_issue <= 1'b1;
          miss_addr  <= req_addr;
        end
      end
      // The miss holds off new requests through its response cycle.
      if (miss_busy && resp_valid) miss_busy <= 1'b0;

      case (state)
        M_IDLE: begin
          if (miss_issue) begin
            state      <= M_LOAD;
            miss_issue <= 1'b0;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= miss_addr;
            mem_wdata  <= '0;
          end else if (sb_count != '0) begin
            state     <= M_STORE;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= sb_addr[head];
            mem_wdata <= sb_data[head];
          end
        end
        M_STORE: begin
          if (mem_ack) begin
            state   <= M_IDLE;
            mem_req <= 1'b0;
          end
        end
        M_LOAD: begin
          if (mem_ack) begin
            state      <= M_IDLE;
            mem_req    <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= mem_rdata;
          end
        end
        default: state <= M_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: default instance for buffer/forward/miss/reset
// scenarios and a DEPTH=8, DATA_W=32 instance for FIFO ordering across pointer wrap.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        rst;

  logic        req_valid, req_write, req_ready, resp_valid, mem_req, mem_we, mem_ack, stall;
  logic [15:0] req_addr, req_wdata, resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  sb_count;

  logic        w_req_valid, w_req_write, w_req_ready, w_resp_valid, w_mem_req, w_mem_we;
  logic        w_mem_ack, w_stall;
  logic [15:0] w_req_addr, w_mem_addr;
  logic [31:0] w_req_wdata, w_resp_rdata, w_mem_wdata, w_mem_rdata;
  logic [3:0]  w_sb_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_access_unit dut (
    .clock(clock), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall), .sb_count(sb_count)
  );

  mem_access_unit #(.DATA_W(32), .ADDR_W(16), .DEPTH(8)) dut8 (
    .clock(clock), .rst(rst),
    .req_valid(w_req_valid), .req_write(w_req_write), .req_addr(w_req_addr),
    .req_wdata(w_req_wdata), .req_ready(w_req_ready), .resp_valid(w_resp_valid),
    .resp_rdata(w_resp_rdata), .mem_req(w_mem_req), .mem_we(w_mem_we),
    .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata), .mem_ack(w_mem_ack),
    .mem_rdata(w_mem_rdata), .stall(w_stall), .sb_count(w_sb_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [15:0] a, input logic [15:0] d);
    req_valid = v; req_write = w; req_addr = a; req_wdata = d;
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (sb_count == 0 && !mem_req) break;
      mem_ack = mem_req;
      step();
      mem_ack = 1'b0;
    end
    check("drain_empty", sb_count, 0);
  endtask

  initial begin
    int sent, got, max_cnt;
    logic saw_stall, acc;

    rst = 1'b0;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; mem_ack = 0; mem_rdata = 0;
    w_req_valid = 0; w_req_write = 0; w_req_addr = 0; w_req_wdata = 0;
    w_mem_ack = 0; w_mem_rdata = 0;
    #3;
    check("rst_ready", req_ready, 1);
    check("rst_count", sb_count, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    #9 rst = 1'b1;
    step();

    // Fill the 4-entry buffer with the port stuck, then free one slot.
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 16'h10 + 16'(i), 16'h100 + 16'(i));
      step();
    end
    drive(1, 1, 16'h14, 16'h104);
    check("full_ready", req_ready, 0);
    check("full_stall", stall, 1);
    check("full_count", sb_count, 4);
    check("full_mem_req", mem_req, 1);
    check("full_mem_we", mem_we, 1);
    check("full_mem_addr", mem_addr, 16'h10);
    check("full_mem_wdata", mem_wdata, 16'h100);
    mem_ack = 1'b1;
    #1 check("full_ready_deq", req_ready, 0);
    step();
    mem_ack = 1'b0;
    #1;
    check("deq_count", sb_count, 3);
    check("deq_ready", req_ready, 1);
    step();
    check("refill_count", sb_count, 4);
    check("refill_mem_addr", mem_addr, 16'h11);
    check("refill_mem_req", mem_req, 1);
    drive(0, 0, 0, 0);
    drain();

    // Youngest-match forwarding across wrapped pointers.
    drive(1, 1, 16'h20, 16'hAAAA);
    step();
    drive(1, 1, 16'h20, 16'hBBBB);
    step();
    drive(1, 0, 16'h20, 0);
    check("fwd_ready", req_ready, 1);
    step();
    check("fwd_resp_valid", resp_valid, 1);
    check("fwd_resp_rdata", resp_rdata, 16'hBBBB);
    check("fwd_mem_we", mem_we, 1);
    drive(0, 0, 0, 0);
    step();
    check("fwd_resp_clear", resp_valid, 0);
    check("fwd_rdata_hold", resp_rdata, 16'hBBBB);
    drain();

    // Hit on the head entry while it drains.
    drive(1, 1, 16'h30, 16'h3333);
    step();
    drive(0, 0, 0, 0);
    step();
    check("headhit_mem_addr", mem_addr, 16'h30);
    drive(1, 0, 16'h30, 0);
    mem_ack = 1'b1;
    step();
    check("headhit_resp_valid", resp_valid, 1);
    check("headhit_resp_rdata", resp_rdata, 16'h3333);
    check("headhit_count", sb_count, 0);
    drive(0, 0, 0, 0);
    step();
    check("idle_ack_mem_req", mem_req, 0);
    check("idle_ack_resp", resp_valid, 0);
    mem_ack = 1'b0;

    // Load miss with three wait cycles.
    drive(1, 0, 16'h40, 0);
    check("miss_ready_pre", req_ready, 1);
    check("miss_stall_pre", stall, 0);
    step();
    drive(0, 0, 0, 0);
    check("miss_ready_acc", req_ready, 0);
    check("miss_mem_req_pre", mem_req, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      check("miss_mem_req", mem_req, 1);
      check("miss_mem_we", mem_we, 0);
      check("miss_mem_addr", mem_addr, 16'h40);
      check("miss_mem_wdata", mem_wdata, 0);
      check("miss_ready", req_ready, 0);
      if (i == 0) begin
        drive(1, 0, 16'h44, 0);
        check("miss_stall", stall, 1);
        drive(0, 0, 0, 0);
      end
      if (i == 3) begin
        mem_ack = 1'b1;
        mem_rdata = 16'h1234;
      end
      step();
    end
    mem_ack = 1'b0;
    mem_rdata = 16'h0;
    check("miss_resp_valid", resp_valid, 1);
    check("miss_resp_rdata", resp_rdata, 16'h1234);
    check("miss_ready_resp", req_ready, 0);
    check("miss_mem_req_done", mem_req, 0);
    step();
    check("miss_resp_clear", resp_valid, 0);
    check("miss_ready_after", req_ready, 1);
    check("miss_rdata_hold", resp_rdata, 16'h1234);

    // Load miss behind an active store.
    drive(1, 1, 16'h60, 16'h6);
    step();
    drive(1, 1, 16'h61, 16'h7);
    step();
    drive(1, 0, 16'h50, 0);
    check("order_ready", req_ready, 1);
    step();
    drive(0, 0, 0, 0);
    check("order_store_addr", mem_addr, 16'h60);
    check("order_store_we", mem_we, 1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("order_gap", mem_req, 0);
    check("order_count", sb_count, 1);
    step();
    check("order_load_req", mem_req, 1);
    check("order_load_we", mem_we, 0);
    check("order_load_addr", mem_addr, 16'h50);
    step();
    check("order_load_hold", mem_addr, 16'h50);
    mem_ack = 1'b1;
    mem_rdata = 16'h5555;
    step();
    mem_ack = 1'b0;
    mem_rdata = 16'h0;
    check("order_resp_valid", resp_valid, 1);
    check("order_resp_rdata", resp_rdata, 16'h5555);
    step();
    check("order_next_req", mem_req, 1);
    check("order_next_we", mem_we, 1);
    check("order_next_addr", mem_addr, 16'h61);
    check("order_next_wdata", mem_wdata, 16'h7);
    check("order_resp_clear", resp_valid, 0);
    drain();

    // Reset in the middle of a load with two stores buffered.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 16'h70 + 16'(i), 16'h700 + 16'(i));
      step();
    end
    drive(1, 0, 16'h80, 0);
    step();
    drive(0, 0, 0, 0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();
    check("rstmid_mem_req", mem_req, 1);
    check("rstmid_mem_we", mem_we, 0);
    check("rstmid_count", sb_count, 2);
    #2 rst = 1'b0;
    #1;
    check("rstmid_drop_req", mem_req, 0);
    check("rstmid_drop_count", sb_count, 0);
    check("rstmid_ready", req_ready, 1);
    check("rstmid_mem_addr", mem_addr, 0);
    mem_ack = 1'b1;
    mem_rdata = 16'hDEAD;
    #4 rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rstmid_no_resp", resp_valid, 0);
      check("rstmid_no_req", mem_req, 0);
    end
    mem_ack = 1'b0;
    mem_rdata = 16'h0;

    // Deep instance: 20 stores streamed through an 8-entry buffer.
    sent = 0; got = 0; max_cnt = 0; saw_stall = 1'b0;
    for (int cyc = 0; cyc < 300 && got < 20; cyc++) begin
      w_req_valid = (sent < 20);
      w_req_write = 1'b1;
      w_req_addr  = 16'(256 + sent);
      w_req_wdata = 32'hC0DE_0000 + 32'(sent);
      w_mem_ack   = w_mem_req && (cyc >= 12);
      #1;
      if (w_stall) saw_stall = 1'b1;
      if (int'(w_sb_count) > max_cnt) max_cnt = int'(w_sb_count);
      if (w_mem_ack) begin
        check("fifo_mem_addr", w_mem_addr, 32'(256 + got));
        check("fifo_mem_wdata", w_mem_wdata, 32'hC0DE_0000 + 32'(got));
        got++;
      end
      acc = w_req_valid && w_req_ready;
      step();
      if (acc) sent++;
    end
    w_req_valid = 1'b0;
    w_mem_ack = 1'b0;
    check("fifo_all_written", 32'(got), 20);
    check("fifo_max_count", 32'(max_cnt), 8);
    check("fifo_saw_stall", saw_stall, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
